// File: rtl/audio_transport_ctrl.sv
// Record/play transport: codec init, SRAM addressing, variable speed, timer.
// Define LOOP_PLAY_EN to wrap playback at end of recording instead of stopping.
module audio_transport_ctrl #(
   parameter int ADDR_W        = 20,
   parameter int MAX_SPEED     = 8,
   parameter int SPD_W         = 4,
   parameter int TICKS_PER_SEC = 32000,
   parameter int TIMER_W       = 5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_key_start,
   input  logic               i_key_stop,
   input  logic               i_key_up,
   input  logic               i_key_down,
   input  logic               i_mode,
   input  logic               i_init_done,
   input  logic               i_sample_tick,
   output logic               o_init_start,
   output logic               o_we,
   output logic               o_re,
   output logic [ADDR_W-1:0]  o_addr,
   output logic [ADDR_W-1:0]  o_max_addr,
   output logic [2:0]         o_state,
   output logic [1:0]         o_speed_mode,
   output logic [SPD_W-1:0]   o_speed,
   output logic [TIMER_W-1:0] o_sec
);
   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_REC   = 3'd2,
      S_PLAY  = 3'd3,
      S_PAUSE = 3'd4
   } state_e;

   localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int AW1   = ADDR_W + 1;
   localparam logic [1:0] SM_NORM = 2'd0;
   localparam logic [1:0] SM_FAST = 2'd1;
   localparam logic [1:0] SM_SLOW = 2'd2;
   localparam logic [SPD_W-1:0] SPD_ONE = SPD_W'(1);
   localparam logic [SPD_W-1:0] SPD_TWO = SPD_W'(2);
   localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(MAX_SPEED);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

   state_e             state_q, state_d;
   logic               play_q, play_d;
   logic               init_q, init_d;
   logic               we_q, we_d;
   logic               re_q, re_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [ADDR_W-1:0]  max_q, max_d;
   logic [1:0]         smode_q, smode_d;
   logic [SPD_W-1:0]   spd_q, spd_d;
   logic [SPD_W-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0]   tcnt_q, tcnt_d;
   logic [TIMER_W-1:0] sec_q, sec_d;

   logic [1:0]       up_mode, dn_mode;
   logic [SPD_W-1:0] up_spd, dn_spd;
   logic [AW1-1:0]   step, nxt;
   logic             adv, count, spd_ok;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_INIT;
         play_q  <= 1'b0;
         init_q  <= 1'b1;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         addr_q  <= '0;
         max_q   <= '0;
         smode_q <= SM_NORM;
         spd_q   <= SPD_ONE;
         hold_q  <= '0;
         tcnt_q  <= '0;
         sec_q   <= '0;
      end else begin
         state_q <= state_d;
         play_q  <= play_d;
         init_q  <= init_d;
         we_q    <= we_d;
         re_q    <= re_d;
         addr_q  <= addr_d;
         max_q   <= max_d;
         smode_q <= smode_d;
         spd_q   <= spd_d;
         hold_q  <= hold_d;
         tcnt_q  <= tcnt_d;
         sec_q   <= sec_d;
      end
   end

   // Speed key targets and the playback step for the current speed setting
   always_comb begin
      up_mode = smode_q;
      up_spd  = spd_q;
      dn_mode = smode_q;
      dn_spd  = spd_q;
      case (smode_q)
         SM_FAST: begin
            if (spd_q < SPD_MAX) up_spd = spd_q + 1'b1;
            if (spd_q <= SPD_TWO) begin
               dn_mode = SM_NORM;
               dn_spd  = SPD_ONE;
            end else begin
               dn_spd = spd_q - 1'b1;
            end
         end
         SM_SLOW: begin
            if (spd_q < SPD_MAX) dn_spd = spd_q + 1'b1;
            if (spd_q <= SPD_TWO) begin
               up_mode = SM_NORM;
               up_spd  = SPD_ONE;
            end else begin
               up_spd = spd_q - 1'b1;
            end
         end
         default: begin
            up_mode = SM_FAST;
            up_spd  = SPD_TWO;
            dn_mode = SM_SLOW;
            dn_spd  = SPD_TWO;
         end
      endcase
      adv  = 1'b1;
      step = AW1'(1);
      if (smode_q == SM_FAST) begin
         step = AW1'(spd_q);
      end else if (smode_q == SM_SLOW) begin
         adv  = (hold_q == spd_q - SPD_ONE);
         step = adv ? AW1'(1) : '0;
      end
      nxt = {1'b0, addr_q} + step;
   end

   always_comb begin
      state_d = state_q;
      play_d  = play_q;
      init_d  = init_q;
      we_d    = 1'b0;
      re_d    = 1'b0;
      addr_d  = addr_q;
      max_d   = max_q;
      smode_d = smode_q;
      spd_d   = spd_q;
      hold_d  = hold_q;
      tcnt_d  = tcnt_q;
      sec_d   = sec_q;
      count   = 1'b0;
      spd_ok  = 1'b0;
      unique case (state_q)
         S_INIT: begin
            if (i_init_done) begin
               state_d = S_IDLE;
               init_d  = 1'b0;
            end
         end
         S_IDLE: begin
            if (i_key_stop) begin
               addr_d  = '0;
               smode_d = SM_NORM;
               spd_d   = SPD_ONE;
               hold_d  = '0;
            end else if (i_key_start) begin
               if (!i_mode || max_q != '0) begin
                  state_d = i_mode ? S_PLAY : S_REC;
                  play_d  = i_mode;
                  addr_d  = '0;
                  hold_d  = '0;
                  tcnt_d  = '0;
                  sec_d   = '0;
                  if (!i_mode) max_d = '0;
               end
            end else begin
               spd_ok = 1'b1;
            end
         end
         S_REC: begin
            smode_d = SM_NORM;
            spd_d   = SPD_ONE;
            if (i_key_stop) begin
               state_d = S_IDLE;
               addr_d  = '0;
            end else begin
               if (i_sample_tick && !i_key_start) begin
                  we_d  = 1'b1;
                  max_d = addr_q;
                  count = 1'b1;
               end
               if (we_q) addr_d = addr_q + 1'b1;
               if (we_q && addr_q == ADDR_LAST) state_d = S_IDLE;
               else if (i_key_start) state_d = S_PAUSE;
            end
         end
         S_PLAY: begin
            if (i_key_stop) begin
               state_d = S_IDLE;
               addr_d  = '0;
               smode_d = SM_NORM;
               spd_d   = SPD_ONE;
               hold_d  = '0;
            end else begin
               if (i_sample_tick && !i_key_start) begin
                  re_d  = 1'b1;
                  count = 1'b1;
               end
               if (re_q) begin
                  if (nxt > {1'b0, max_q}) begin
                     addr_d = '0;
                     hold_d = '0;
`ifndef LOOP_PLAY_EN
                     state_d = S_IDLE;
`endif
                  end else begin
                     addr_d = nxt[ADDR_W-1:0];
                     hold_d = adv ? '0 : hold_q + 1'b1;
                  end
               end
               if (i_key_start) begin
                  if (state_d == S_PLAY) state_d = S_PAUSE;
               end else begin
                  spd_ok = 1'b1;
               end
            end
         end
         S_PAUSE: begin
            if (i_key_stop) begin
               state_d = S_IDLE;
               addr_d  = '0;
               smode_d = SM_NORM;
               spd_d   = SPD_ONE;
               hold_d  = '0;
            end else if (i_key_start) begin
               state_d = play_q ? S_PLAY : S_REC;
            end else begin
               spd_ok = 1'b1;
            end
         end
         default: state_d = S_INIT;
      endcase
      if (spd_ok && i_key_up) begin
         smode_d = up_mode;
         spd_d   = up_spd;
         hold_d  = '0;
      end else if (spd_ok && i_key_down) begin
         smode_d = dn_mode;
         spd_d   = dn_spd;
         hold_d  = '0;
      end
      if (count) begin
         if (tcnt_q == TCNT_LAST) begin
            tcnt_d = '0;
            if (sec_q != '1) sec_d = sec_q + 1'b1;
         end else begin
            tcnt_d = tcnt_q + 1'b1;
         end
      end
   end

   assign o_init_start = init_q;
   assign o_we         = we_q;
   assign o_re         = re_q;
   assign o_addr       = addr_q;
   assign o_max_addr   = max_q;
   assign o_state      = state_q;
   assign o_speed_mode = smode_q;
   assign o_speed      = spd_q;
   assign o_sec        = sec_q;
endmodule

// File: tb/tb_audio_transport_ctrl.sv
// Directed bench for audio_transport_ctrl, small geometry:
// ADDR_W=4, MAX_SPEED=8, TICKS_PER_SEC=4, TIMER_W=2.
module tb_audio_transport_ctrl;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst, k_start, k_stop, k_up, k_down, mode, init_done, tick;
   logic          init_start, we, re;
   logic [AW-1:0] addr, max_addr;
   logic [2:0]    state;
   logic [1:0]    smode, sec;
   logic [3:0]    speed;

   int n_tests = 0;
   int n_fail  = 0;

   audio_transport_ctrl #(
      .ADDR_W(AW), .MAX_SPEED(8), .SPD_W(4),
      .TICKS_PER_SEC(4), .TIMER_W(2)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_key_start(k_start), .i_key_stop(k_stop),
      .i_key_up(k_up), .i_key_down(k_down),
      .i_mode(mode), .i_init_done(init_done),
      .i_sample_tick(tick),
      .o_init_start(init_start), .o_we(we), .o_re(re),
      .o_addr(addr), .o_max_addr(max_addr), .o_state(state),
      .o_speed_mode(smode), .o_speed(speed), .o_sec(sec)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input bit st, input bit sp,
                        input bit up, input bit dn);
      k_start = st;
      k_stop  = sp;
      k_up    = up;
      k_down  = dn;
      cyc();
      k_start = 1'b0;
      k_stop  = 1'b0;
      k_up    = 1'b0;
      k_down  = 1'b0;
   endtask

   task automatic do_tick(output logic w, output logic r,
                          output logic [AW-1:0] a);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      w = we;
      r = re;
      a = addr;
      cyc();
      check("strobe_width", int'(we | re), 0);
      cyc();
   endtask

   logic          w, r;
   logic [AW-1:0] a;

   initial begin
      rst = 1'b1; k_start = 0; k_stop = 0; k_up = 0; k_down = 0;
      mode = 0; init_done = 0; tick = 0;
      cyc(); cyc();
      rst = 1'b0;
      check("rst_state", state, 0);
      check("rst_init", init_start, 1);
      check("rst_we_re", int'({we, re}), 0);
      check("rst_addr", addr, 0);
      check("rst_max", max_addr, 0);
      check("rst_smode", smode, 0);
      check("rst_speed", speed, 1);
      check("rst_sec", sec, 0);

      press(1, 0, 1, 0);
      check("init_keys_ign", state, 0);
      check("init_spd_ign", smode, 0);
      cyc(); cyc(); cyc();
      check("init_held", init_start, 1);
      init_done = 1'b1;
      cyc();
      init_done = 1'b0;
      check("init_to_idle", state, 1);
      check("init_start_lo", init_start, 0);

      mode = 0;
      press(1, 0, 0, 0);
      check("rec_enter", state, 2);
      for (int i = 0; i < 10; i++) begin
         do_tick(w, r, a);
         check("rec_we", w, 1);
         check("rec_addr", a, i);
      end
      check("rec_sec10", sec, 2);
      check("rec_max", max_addr, 9);
      press(0, 1, 0, 0);
      check("rec_stop_st", state, 1);
      check("rec_stop_addr", addr, 0);
      check("rec_stop_max", max_addr, 9);

      press(0, 0, 1, 0);
      press(0, 0, 1, 0);
      check("fast_mode", smode, 1);
      check("fast3", speed, 3);
      mode = 1;
      press(1, 0, 0, 0);
      check("play_enter", state, 3);
      check("play_sec0", sec, 0);
      for (int i = 0; i < 4; i++) begin
         do_tick(w, r, a);
         check("fast_re", r, 1);
         check("fast_addr", a, 3 * i);
      end
`ifdef LOOP_PLAY_EN
      check("loop_state", state, 3);
      check("loop_addr", addr, 0);
      do_tick(w, r, a);
      check("loop_re", r, 1);
      check("loop_addr0", a, 0);
      press(0, 1, 0, 0);
`else
      check("end_state", state, 1);
      check("end_addr", addr, 0);
      do_tick(w, r, a);
      check("end_no_re", r, 0);
      press(0, 1, 0, 0);
`endif
      check("stop_norm", smode, 0);
      check("stop_spd1", speed, 1);

      press(0, 0, 0, 1);
      check("slow_mode", smode, 2);
      check("slow2", speed, 2);
      press(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         do_tick(w, r, a);
         check("slow_re", r, 1);
         check("slow_addr", a, i / 2);
      end
      press(1, 0, 0, 0);
      check("pause_state", state, 4);
      for (int i = 0; i < 10; i++) begin
         do_tick(w, r, a);
         check("pause_no_re", r, 0);
      end
      check("pause_addr", addr, 2);
      check("pause_sec", sec, 1);
      press(1, 0, 0, 0);
      check("resume_state", state, 3);
      do_tick(w, r, a);
      check("resume_addr2", a, 2);
      do_tick(w, r, a);
      check("resume_addr3", a, 3);
      press(0, 1, 0, 0);

      mode = 0;
      press(1, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         do_tick(w, r, a);
         check("full_we", w, 1);
         check("full_addr", a, i);
         check("timer_sec", sec, ((i + 1) / 4 > 3) ? 3 : (i + 1) / 4);
      end
      check("full_idle", state, 1);
      check("full_max", max_addr, 15);
      check("full_wrap", addr, 0);

      mode = 1;
      press(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) press(0, 0, 1, 0);
      check("sat_mode", smode, 1);
      check("sat_speed", speed, 8);
      do_tick(w, r, a);
      check("f8_addr0", a, 0);
      do_tick(w, r, a);
      check("f8_addr8", a, 8);
      check("f8_end", state, 1);

      press(0, 1, 0, 0);
      press(0, 0, 1, 1);
      check("up_over_down", smode, 1);
      check("up_over_dn_s", speed, 2);
      press(0, 0, 0, 1);
      press(0, 0, 0, 1);
      press(0, 0, 1, 0);
      check("slow2_up_norm", smode, 0);
      press(1, 0, 0, 0);
      check("play_again", state, 3);
      press(1, 1, 0, 0);
      check("stop_wins", state, 1);

      mode = 0;
      press(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) do_tick(w, r, a);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("mid_rst_state", state, 0);
      check("mid_rst_max", max_addr, 0);
      check("mid_rst_init", init_start, 1);
      init_done = 1'b1;
      cyc();
      init_done = 1'b0;
      mode = 1;
      press(1, 0, 0, 0);
      check("play_no_rec", state, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
